// File: rtl/mil_rt_msg.sv
// MIL-STD-1553 remote-terminal message sequencer.
// Decodes commands, collects data words and requests the status reply.
module mil_rt_msg #(
    parameter logic [4:0] RT_ADR = 5'd3,
    parameter int         T_GAP  = 1400
) (
    input  logic        clk,
    input  logic        R,
    input  logic        ok_rx,
    input  logic [15:0] sr_dat,
    input  logic        CW_DW,
    output logic        busy,
    output logic        tr,
    output logic [4:0]  sub_adr,
    output logic [5:0]  wc,
    output logic [15:0] dat_out,
    output logic [4:0]  dat_idx,
    output logic        dat_we,
    output logic        st_req,
    output logic [15:0] ST_W,
    output logic        msg_ok,
    output logic        msg_err
);

    localparam int             GW     = $clog2(T_GAP + 1);
    localparam logic [GW-1:0]  GAP_LD = GW'(T_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX_DW = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [5:0]    cnt;
    logic [GW-1:0] gap;
    logic          bc;
    logic          me;
    logic          bcr;

    logic          cmd_hit;
    logic          cmd_nodata;
    logic          ld_cmd;
    logic          dw_acc;
    logic          abort;
    logic          timeout;

    logic [4:0]    f_adr;
    logic [4:0]    f_sa;

    assign f_adr = sr_dat[15:11];
    assign f_sa  = sr_dat[9:5];

    assign cmd_hit = ok_rx && CW_DW
                   && (f_adr == RT_ADR || f_adr == 5'd31);
    assign cmd_nodata = sr_dat[10]
                      || f_sa == 5'd0 || f_sa == 5'd31;

    assign busy = (state_q != IDLE);
    assign ST_W = {RT_ADR, me, 5'b0, bcr, 4'b0};

    // Next-state decode and per-cycle control flags
    always_comb begin
        state_d = state_q;
        ld_cmd  = 1'b0;
        dw_acc  = 1'b0;
        abort   = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_hit) begin
                    ld_cmd  = 1'b1;
                    state_d = cmd_nodata ? RESP : RX_DW;
                end
            end
            RX_DW: begin
                if (ok_rx && CW_DW) begin
                    abort = 1'b1;
                    if (cmd_hit) begin
                        ld_cmd  = 1'b1;
                        state_d = cmd_nodata ? RESP : RX_DW;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ok_rx) begin
                    dw_acc = 1'b1;
                    if (cnt + 6'd1 == wc) begin
                        state_d = RESP;
                    end
                end else if (gap == '0) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, latched command fields, counters and strobes
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            tr      <= 1'b0;
            sub_adr <= '0;
            wc      <= '0;
            bc      <= 1'b0;
            cnt     <= '0;
            gap     <= '0;
            dat_out <= '0;
            dat_idx <= '0;
            dat_we  <= 1'b0;
            st_req  <= 1'b0;
            msg_ok  <= 1'b0;
            msg_err <= 1'b0;
            me      <= 1'b0;
            bcr     <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_we  <= dw_acc;
            msg_err <= abort | timeout;
            msg_ok  <= (state_q == RESP);
            st_req  <= (state_q == RESP) && !bc;

            if (ld_cmd) begin
                tr      <= sr_dat[10];
                sub_adr <= f_sa;
                wc      <= (sr_dat[4:0] == 5'd0) ? 6'd32
                                                 : {1'b0, sr_dat[4:0]};
                bc      <= (f_adr == 5'd31);
                cnt     <= '0;
            end else if (dw_acc) begin
                cnt <= cnt + 6'd1;
            end

            if (dw_acc) begin
                dat_out <= sr_dat;
                dat_idx <= cnt[4:0];
            end

            if (ok_rx || (state_d == RX_DW && state_q != RX_DW)) begin
                gap <= GAP_LD;
            end else if (state_q == RX_DW && gap != '0) begin
                gap <= gap - 1'b1;
            end

            // ME/BCR stay set until the status word carrying them is sent
            if (abort || timeout) begin
                me <= 1'b1;
            end else if (st_req) begin
                me <= 1'b0;
            end

            if (state_q == RESP && bc) begin
                bcr <= 1'b1;
            end else if (st_req) begin
                bcr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mil_rt_msg.sv
// Directed bench for mil_rt_msg.
// Command table plus hand-written multi-cycle message sequences.
module tb_mil_rt_msg;

    localparam int TG = 1400;

    logic        clk = 1'b0;
    logic        R;
    logic        ok_rx;
    logic [15:0] sr_dat;
    logic        CW_DW;
    logic        busy;
    logic        tr;
    logic [4:0]  sub_adr;
    logic [5:0]  wc;
    logic [15:0] dat_out;
    logic [4:0]  dat_idx;
    logic        dat_we;
    logic        st_req;
    logic [15:0] ST_W;
    logic        msg_ok;
    logic        msg_err;

    int n_cmp = 0;
    int n_bad = 0;
    int c_we  = 0;
    int c_st  = 0;
    int c_ok  = 0;
    int c_err = 0;
    logic [4:0] last_idx = '0;

    mil_rt_msg #(.RT_ADR(5'd3), .T_GAP(TG)) dut (
        .clk     (clk),
        .R       (R),
        .ok_rx   (ok_rx),
        .sr_dat  (sr_dat),
        .CW_DW   (CW_DW),
        .busy    (busy),
        .tr      (tr),
        .sub_adr (sub_adr),
        .wc      (wc),
        .dat_out (dat_out),
        .dat_idx (dat_idx),
        .dat_we  (dat_we),
        .st_req  (st_req),
        .ST_W    (ST_W),
        .msg_ok  (msg_ok),
        .msg_err (msg_err)
    );

    always #5 clk = ~clk;

    // Strobe tally, sampled mid-cycle
    always @(negedge clk) begin
        if (dat_we) begin
            c_we++;
            last_idx <= dat_idx;
        end
        if (st_req) c_st++;
        if (msg_ok) c_ok++;
        if (msg_err) c_err++;
    end

    typedef struct {
        logic [15:0] w;
        logic        cw;
        logic        acc;
        logic        tr;
        logic [4:0]  sa;
        logic [5:0]  wc;
        logic        st;
        logic [15:0] stw;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic cw);
        ok_rx  = 1'b1;
        sr_dat = w;
        CW_DW  = cw;
        tick();
        ok_rx  = 1'b0;
        sr_dat = '0;
        CW_DW  = 1'b0;
    endtask

    task automatic clr_cnt();
        c_we  = 0;
        c_st  = 0;
        c_ok  = 0;
        c_err = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   busy,    0);
        chk({tag, "_tr"},     tr,      0);
        chk({tag, "_sa"},     sub_adr, 0);
        chk({tag, "_wc"},     wc,      0);
        chk({tag, "_dout"},   dat_out, 0);
        chk({tag, "_didx"},   dat_idx, 0);
        chk({tag, "_strobe"},
            {dat_we, st_req, msg_ok, msg_err}, 0);
        chk({tag, "_stw"},    ST_W,    16'h1800);
    endtask

    initial begin
        int n;
        R      = 1'b0;
        ok_rx  = 1'b0;
        sr_dat = '0;
        CW_DW  = 1'b0;

        tv[0] = '{16'h1C21, 1'b1, 1'b1, 1'b1, 5'd1,  6'd1,  1'b1, 16'h1800};
        tv[1] = '{16'h1800, 1'b1, 1'b1, 1'b0, 5'd0,  6'd32, 1'b1, 16'h1800};
        tv[2] = '{16'h1BE5, 1'b1, 1'b1, 1'b0, 5'd31, 6'd5,  1'b1, 16'h1800};
        tv[3] = '{16'h2043, 1'b1, 1'b0, 1'b0, 5'd0,  6'd0,  1'b0, 16'h1800};
        tv[4] = '{16'h1843, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0,  1'b0, 16'h1800};
        tv[5] = '{16'hFC3F, 1'b1, 1'b1, 1'b1, 5'd1,  6'd31, 1'b0, 16'h1810};
        tv[6] = '{16'h1C21, 1'b1, 1'b1, 1'b1, 5'd1,  6'd1,  1'b1, 16'h1810};

        repeat (3) tick();
        chk_reset_vals("rst");
        R = 1'b1;
        tick();

        // Single-word commands from IDLE
        for (int i = 0; i < 7; i++) begin
            send(tv[i].w, tv[i].cw);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].acc);
            if (tv[i].acc) begin
                chk($sformatf("tv%0d_tr", i), tr, tv[i].tr);
                chk($sformatf("tv%0d_sa", i), sub_adr, tv[i].sa);
                chk($sformatf("tv%0d_wc", i), wc, tv[i].wc);
            end
            tick();
            chk($sformatf("tv%0d_st", i), st_req, tv[i].st);
            chk($sformatf("tv%0d_ok", i), msg_ok, tv[i].acc);
            chk($sformatf("tv%0d_err_we", i), {msg_err, dat_we}, 0);
            chk($sformatf("tv%0d_stw", i), ST_W, tv[i].stw);
            tick();
        end

        // Receive of three data words
        clr_cnt();
        send(16'h1843, 1'b1);
        chk("rx3_busy", busy, 1);
        chk("rx3_wc", wc, 3);
        chk("rx3_sa", sub_adr, 2);
        for (int i = 0; i < 3; i++) begin
            send(16'hA000 + 16'(i), 1'b0);
            chk($sformatf("rx3_we%0d", i), dat_we, 1);
            chk($sformatf("rx3_idx%0d", i), dat_idx, i);
            chk($sformatf("rx3_dat%0d", i), dat_out, 16'hA000 + i);
        end
        chk("rx3_early_st", st_req, 0);
        tick();
        chk("rx3_st", st_req, 1);
        chk("rx3_ok", msg_ok, 1);
        chk("rx3_stw", ST_W, 16'h1800);
        tick();
        chk("rx3_cnt", {8'(c_we), 8'(c_st), 8'(c_ok), 8'(c_err)},
            {8'd3, 8'd1, 8'd1, 8'd0});

        // Word count field 0 means 32 words
        clr_cnt();
        send(16'h1840, 1'b1);
        chk("wc32_wc", wc, 32);
        for (int i = 0; i < 32; i++) begin
            send(16'h0100 + 16'(i), 1'b0);
        end
        chk("wc32_lastidx", dat_idx, 31);
        chk("wc32_lastdat", dat_out, 16'h011F);
        tick();
        chk("wc32_st", st_req, 1);
        tick();
        chk("wc32_cnt", {8'(c_we), 8'(c_st), 8'(c_ok)},
            {8'd32, 8'd1, 8'd1});

        // Inter-word timeout
        clr_cnt();
        send(16'h1843, 1'b1);
        send(16'h5555, 1'b0);
        n = 0;
        for (int k = 1; k <= TG + 20; k++) begin
            tick();
            if (msg_err) begin
                n = k;
                break;
            end
        end
        chk("to_cycles", n, TG);
        tick();
        chk("to_busy", busy, 0);
        send(16'h1C21, 1'b1);
        tick();
        chk("to_st", st_req, 1);
        chk("to_stw_me", ST_W, 16'h1C00);
        tick();
        chk("to_stw_clr", ST_W, 16'h1800);
        chk("to_err_cnt", c_err, 1);

        // Broadcast receive, BCR reported on next status
        clr_cnt();
        send(16'hF842, 1'b1);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        tick();
        chk("bc_ok", msg_ok, 1);
        chk("bc_nost", st_req, 0);
        chk("bc_stw", ST_W, 16'h1810);
        tick();
        send(16'h1C21, 1'b1);
        tick();
        chk("bc_st", st_req, 1);
        chk("bc_stw_rep", ST_W, 16'h1810);
        tick();
        chk("bc_stw_clr", ST_W, 16'h1800);
        chk("bc_cnt", {8'(c_st), 8'(c_ok), 8'(c_we)},
            {8'd1, 8'd2, 8'd2});

        // Foreign address and orphan data word
        clr_cnt();
        send(16'h2043, 1'b1);
        chk("oth_busy", busy, 0);
        send(16'h1234, 1'b0);
        chk("orph_busy", busy, 0);
        repeat (3) tick();
        chk("oth_quiet", c_we + c_st + c_ok + c_err, 0);

        // Superseding command
        clr_cnt();
        send(16'h1843, 1'b1);
        send(16'h7777, 1'b0);
        send(16'h1C21, 1'b1);
        chk("sup_err", msg_err, 1);
        chk("sup_tr", tr, 1);
        tick();
        chk("sup_st", st_req, 1);
        chk("sup_stw", ST_W, 16'h1C00);
        tick();
        chk("sup_cnt", {8'(c_err), 8'(c_st)}, {8'd1, 8'd1});

        // Reset during data phase
        send(16'h1843, 1'b1);
        send(16'h8888, 1'b0);
        clr_cnt();
        R = 1'b0;
        #1;
        chk_reset_vals("mrst");
        repeat (2) tick();
        R = 1'b1;
        repeat (TG + 5) tick();
        chk("mrst_quiet", {8'(c_err), 8'(c_st), 8'(c_ok)}, 0);
        chk("mrst_idle", busy, 0);
        send(16'h1C21, 1'b1);
        tick();
        chk("mrst_st", st_req, 1);
        chk("mrst_stw", ST_W, 16'h1800);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mil_rt_msg.md
MIL_RT_MSG -- requirements
Module: MIL_RT_MSG

Interface
REQ-001 SHALL have parameter RT_ADR, default 5'd3: own remote-terminal address.
REQ-002 SHALL have parameter T_GAP, default 1400: inter-word timeout in clk cycles (28 us at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock, 50 MHz, all logic on the rising edge.
REQ-004 SHALL have port R, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ok_rx, input, 1 bit: one-cycle strobe, a word was received with valid parity.
REQ-006 SHALL have port sr_dat, input, 16 bits: received word, valid while ok_rx=1.
REQ-007 SHALL have port CW_DW, input, 1 bit: sync type of the word; 1 = command/status sync, 0 = data sync.
REQ-008 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-009 SHALL have port tr, output, 1 bit: latched T/R bit (sr_dat[10]).
REQ-010 SHALL have port sub_adr, output, 5 bits: latched sr_dat[9:5].
REQ-011 SHALL have port wc, output, 6 bits: decoded word count, 1..32.
REQ-012 SHALL have port dat_out, output, 16 bits: received data word.
REQ-013 SHALL have port dat_idx, output, 5 bits: index of dat_out within the message.
REQ-014 SHALL have port dat_we, output, 1 bit: one-cycle write strobe for dat_out/dat_idx.
REQ-015 SHALL have port st_req, output, 1 bit: one-cycle request to the transmitter to send ST_W.
REQ-016 SHALL have port ST_W, output, 16 bits: status word.
REQ-017 SHALL have port msg_ok, output, 1 bit: one-cycle strobe, message completed.
REQ-018 SHALL have port msg_err, output, 1 bit: one-cycle strobe, message aborted.

Function
REQ-019 SHALL implement an FSM with the states IDLE, RX_DW, RESP; no other states are reachable.
REQ-020 In IDLE, ok_rx with CW_DW=1 and sr_dat[15:11] equal to RT_ADR or 31 SHALL be accepted as a command; any other word SHALL be ignored.
REQ-021 On an accepted command, tr, sub_adr and wc SHALL update on the next clock edge; the broadcast flag bc SHALL be set when sr_dat[15:11]=31; the word counter SHALL be cleared.
REQ-022 wc SHALL equal sr_dat[4:0] for field values 1..31 and SHALL equal 32 for field value 0.
REQ-023 A mode command (sub_adr 0 or 31) and a transmit command (tr=1) SHALL go IDLE->RESP, with no data phase.
REQ-024 A receive command (tr=0, sub_adr 1..30) SHALL go IDLE->RX_DW.
REQ-025 In RX_DW, each ok_rx with CW_DW=0 SHALL drive dat_out=sr_dat, dat_idx=counter and dat_we=1 one cycle later, then increment the counter.
REQ-026 When the counter reaches wc, the state SHALL go RX_DW->RESP on that same edge.
REQ-027 In RX_DW, ok_rx with CW_DW=1 SHALL abort the message (msg_err pulse, ME set) and SHALL re-decode that word as a new command per REQ-020..024.
REQ-028 The gap counter SHALL reload on every ok_rx and on entry to RX_DW; T_GAP cycles without ok_rx in RX_DW SHALL give msg_err=1 for one cycle, set ME, and return to IDLE.
REQ-029 RESP SHALL last exactly one cycle: msg_ok=1; st_req=1 only if bc=0; if bc=1, BCR SHALL be set instead; next state IDLE.
REQ-030 ST_W SHALL be {RT_ADR, ME, 5'b0, BCR, 4'b0}: ME at bit 10, BCR at bit 4.
REQ-031 ME and BCR SHALL be sticky; both SHALL clear on the edge after an st_req pulse, so that the pulsed ST_W still carries them.
REQ-032 The latency from the last data-word ok_rx to st_req SHALL be 2 cycles; from a mode or transmit command ok_rx to st_req SHALL be 2 cycles.
REQ-033 ok_rx while in RESP SHALL be ignored.

Reset
REQ-034 While R=0, the state SHALL be IDLE, all strobes 0, busy=0, tr=0, sub_adr=0, wc=0, dat_out=0, dat_idx=0, counters=0, ME=BCR=bc=0, and ST_W={RT_ADR,11'b0}.
REQ-035 R asserted mid-message SHALL discard the message without a msg_err or st_req pulse; after release the block SHALL wait for a new command.

Verification
REQ-036 The bench SHALL cover a receive of 3 words: CW 16'h1843 (adr 3, R, sa 2, wc 3) + 3 DWs -> 3 dat_we with idx 0,1,2, then msg_ok and st_req with ST_W=16'h1800.
REQ-037 The bench SHALL cover wc field 0: CW 16'h1840 + 32 DWs -> wc=32, last dat_idx=31, single st_req.
REQ-038 The bench SHALL cover a timeout: CW 16'h1843 + 1 DW, then silence for T_GAP cycles -> msg_err; the next CW 16'h1C21 (transmit) -> st_req with ST_W=16'h1C00 (ME set), then ST_W returns to 16'h1800.
REQ-039 The bench SHALL cover a broadcast: CW 16'hF842 + 2 DWs -> msg_ok with no st_req; the next addressed transmit command reports ST_W=16'h1810.
REQ-040 The bench SHALL cover other-address and orphan words: CW 16'h2043 and a DW while IDLE -> no output activity and busy=0.
REQ-041 The bench SHALL cover a superseding command and reset: CW 16'h1843, 1 DW, CW 16'h1C21 -> msg_err, then st_req; R=0 during RX_DW -> all outputs return to their reset values, with no strobe.
